// File: rtl/decode_pkg.sv
// Shared decode definitions: default geometry, field position helpers
// and the sign-extension helper used by execute and bench models.
package decode_pkg;

  localparam int INSTR_W_D = 32;
  localparam int OP_W_D    = 4;
  localparam int REG_W_D   = 4;
  localparam int SEXT_W    = 64;

  function automatic int cs_w(int iw, int ow, int rw);
    return iw - 2*ow - 1 - 3*rw;
  endfunction

  function automatic int cm_w(int iw, int ow, int rw);
    return iw - ow - 3*rw;
  endfunction

  function automatic int cl_w(int iw, int ow);
    return iw - ow - 1;
  endfunction

  function automatic int op_lsb(int iw, int ow);
    return iw - ow;
  endfunction

  function automatic int ce_bit(int iw, int ow);
    return iw - ow - 1;
  endfunction

  function automatic int opc_lsb(int iw, int ow);
    return iw - 2*ow - 1;
  endfunction

  function automatic int k_lsb(int rw);
    return 3*rw;
  endfunction

  // Replicates bit [width-1] of field above the field.
  function automatic logic [SEXT_W-1:0] sext(
    input logic [SEXT_W-1:0] field,
    input int unsigned       width
  );
    logic [SEXT_W-1:0] r;
    r = '0;
    for (int i = 0; i < SEXT_W; i++) begin
      if (i < int'(width)) r[i] = field[i];
      else                 r[i] = field[width-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// Fetch->decode and decode->execute valid/ready handshake bundle.
// slave: the decode stage; master: the fetch/execute side.
interface instr_decode_stage_if
  import decode_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_D
);

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;

  modport slave (
    input  in_valid,
    input  in_instr,
    input  out_ready,
    output in_ready,
    output out_valid
  );

  modport master (
    output in_valid,
    output in_instr,
    output out_ready,
    input  in_ready,
    input  out_valid
  );

endinterface

// File: rtl/decode_skid_buf.sv
// 2-entry valid/ready skid buffer: output register plus one skid slot.
// Ports: clk, rst_n, flush, in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module decode_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             in_xfer;
  logic             out_load;

  // in_ready depends on registered state only, so out_ready
  // never reaches fetch combinationally.
  assign in_ready = !skid_valid;
  assign in_xfer  = in_valid && in_ready;
  assign out_load = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      // out_data is kept so fields hold their last value.
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_load) begin
      if (skid_valid) begin
        // in_ready was low, so no new word competes here.
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_xfer) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage: skid-buffered word split into fields.
// Ports: clk, nreset, flush, bus (handshake + in_instr), decoded fields.
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_D,
  parameter int OP_W    = OP_W_D,
  parameter int REG_W   = REG_W_D,
  parameter logic [(2**OP_W)-1:0] LEGAL_MASK = {(2**OP_W){1'b1}},
  localparam int CS_W = cs_w(INSTR_W, OP_W, REG_W),
  localparam int CM_W = cm_w(INSTR_W, OP_W, REG_W),
  localparam int CL_W = cl_w(INSTR_W, OP_W)
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                flush,
  instr_decode_stage_if.slave bus,
  output logic [OP_W-1:0]     instrOP,
  output logic                ce,
  output logic [OP_W-1:0]     opcode,
  output logic [CS_W-1:0]     const_s,
  output logic [CM_W-1:0]     const_m,
  output logic [CL_W-1:0]     const_l,
  output logic [INSTR_W-1:0]  const_s_sx,
  output logic [INSTR_W-1:0]  const_m_sx,
  output logic [REG_W-1:0]    areg,
  output logic [REG_W-1:0]    breg,
  output logic [REG_W-1:0]    dreg,
  output logic                he,
  output logic                oe,
  output logic                illegal
);

  localparam int OPL = op_lsb(INSTR_W, OP_W);
  localparam int CEB = ce_bit(INSTR_W, OP_W);
  localparam int OCL = opc_lsb(INSTR_W, OP_W);
  localparam int KL  = k_lsb(REG_W);

  if (OP_W < 1 || REG_W < 1 ||
      INSTR_W < 2*OP_W + 3*REG_W + 2) begin : g_bad_geom
    $error("instr_decode_stage: field layout does not fit");
  end

  logic [INSTR_W-1:0] word;

  decode_skid_buf #(
    .WIDTH (INSTR_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (nreset),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (bus.in_instr),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (word)
  );

  assign instrOP = word[OPL +: OP_W];
  assign ce      = word[CEB];
  assign opcode  = word[OCL +: OP_W];
  assign const_s = word[KL +: CS_W];
  assign const_m = word[KL +: CM_W];
  assign const_l = word[1 +: CL_W];
  assign areg    = word[2*REG_W +: REG_W];
  assign breg    = word[REG_W +: REG_W];
  assign dreg    = word[0 +: REG_W];
  assign he      = word[2*REG_W];
  assign oe      = word[0];

  assign const_s_sx = {{(INSTR_W-CS_W){const_s[CS_W-1]}}, const_s};
  assign const_m_sx = {{(INSTR_W-CM_W){const_m[CM_W-1]}}, const_m};

  // Illegal opcodes still flow through; execute raises the trap.
  assign illegal = !LEGAL_MASK[instrOP];

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: FIFO-level model plus directed vectors.
// Model checks every cycle; literals pin decode, order and flush cases.
module tb_instr_decode_stage;
  import decode_pkg::*;

  localparam logic [15:0] LM = 16'h7FFF;

  logic clk = 1'b0;
  logic nreset;
  logic flush;
  always #5 clk = ~clk;

  instr_decode_stage_if #(.INSTR_W(32)) bus ();

  logic [3:0]  instrOP, opcode;
  logic        ce, he, oe, illegal;
  logic [10:0] const_s;
  logic [15:0] const_m;
  logic [26:0] const_l;
  logic [31:0] const_s_sx, const_m_sx;
  logic [3:0]  areg, breg, dreg;

  instr_decode_stage #(
    .INSTR_W(32), .OP_W(4), .REG_W(4), .LEGAL_MASK(LM)
  ) dut (
    .clk(clk), .nreset(nreset), .flush(flush), .bus(bus),
    .instrOP(instrOP), .ce(ce), .opcode(opcode),
    .const_s(const_s), .const_m(const_m), .const_l(const_l),
    .const_s_sx(const_s_sx), .const_m_sx(const_m_sx),
    .areg(areg), .breg(breg), .dreg(dreg),
    .he(he), .oe(oe), .illegal(illegal)
  );

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dword();
    return {instrOP, const_l, oe};
  endfunction

  // Model: the stage is a 2-deep FIFO; head is what the fields show.
  logic [31:0] q[$];
  logic [31:0] shown;
  logic        m_ov, m_ir;
  logic [31:0] log_q[$];

  always @(posedge clk) begin
    if (!nreset) begin
      q.delete();
      shown = 32'h0;
    end else begin
      m_ov = q.size() > 0;
      m_ir = q.size() < 2;
      if (m_ov && bus.out_ready) void'(q.pop_front());
      if (flush) q.delete();
      else if (bus.in_valid && m_ir) q.push_back(bus.in_instr);
      if (q.size() > 0) shown = q[0];
    end
  end

  logic [31:0] e_cs, e_cm;
  always @(negedge clk) begin
    if (nreset) begin
      e_cs = (shown >> 12) & 32'h7FF;
      e_cm = (shown >> 12) & 32'hFFFF;
      chk("m_out_valid", bus.out_valid, q.size() > 0);
      chk("m_in_ready", bus.in_ready, q.size() < 2);
      chk("m_word", dword(), shown);
      chk("m_ce", ce, (shown >> 27) & 1);
      chk("m_opcode", opcode, (shown >> 23) & 15);
      chk("m_const_s", const_s, e_cs);
      chk("m_const_m", const_m, e_cm);
      chk("m_const_s_sx", const_s_sx,
          e_cs >= 32'h400 ? (e_cs | 32'hFFFFF800) : e_cs);
      chk("m_const_m_sx", const_m_sx,
          e_cm >= 32'h8000 ? (e_cm | 32'hFFFF0000) : e_cm);
      chk("m_areg", areg, (shown >> 8) & 15);
      chk("m_breg", breg, (shown >> 4) & 15);
      chk("m_dreg", dreg, shown & 15);
      chk("m_he", he, (shown >> 8) & 1);
      chk("m_illegal", illegal, !LM[shown[31:28]]);
      if (bus.out_valid && bus.out_ready) log_q.push_back(dword());
    end
  end

  logic acc;

  // Drive one cycle; acc reports whether the word was taken.
  task automatic cyc(logic v, logic [31:0] w, logic rdy, logic fl);
    bus.in_valid  = v;
    bus.in_instr  = w;
    bus.out_ready = rdy;
    flush         = fl;
    @(negedge clk);
    acc = v && bus.in_ready;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] s [8];
  logic        sent;

  initial begin
    nreset        = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_word", dword(), 0);
    chk("rst_const_m_sx", const_m_sx, 0);
    nreset = 1'b1;

    cyc(1, 32'h08ABC123, 1, 0);
    chk("dec_valid", bus.out_valid, 1);
    chk("dec_instrOP", instrOP, 0);
    chk("dec_ce", ce, 1);
    chk("dec_opcode", opcode, 1);
    chk("dec_const_m", const_m, 16'h8ABC);
    chk("dec_const_m_sx", const_m_sx, 32'hFFFF8ABC);
    chk("dec_const_s", const_s, 11'h2BC);
    chk("dec_const_s_sx", const_s_sx, 32'h000002BC);
    chk("dec_const_l", const_l, 27'h455E091);
    chk("dec_areg", areg, 1);
    chk("dec_breg", breg, 2);
    chk("dec_dreg", dreg, 3);
    chk("dec_he", he, 1);
    chk("dec_oe", oe, 1);
    chk("dec_sext_fn", sext(64'h2BC, 11), 64'h2BC);
    chk("dec_sext_fn_neg", sext(64'h8ABC, 16), 64'hFFFFFFFFFFFF8ABC);
    cyc(0, 0, 1, 0);
    chk("dec_drained", bus.out_valid, 0);
    chk("dec_fields_kept", const_m, 16'h8ABC);

    log_q.delete();
    for (int i = 0; i < 8; i++) s[i] = 32'h1234_0000 + i * 32'h0101_0111;
    for (int i = 0; i < 8; i++) begin
      cyc(1, s[i], 1, 0);
      chk("stream_accept", acc, 1);
      chk("stream_out_valid", bus.out_valid, 1);
      chk("stream_out_word", dword(), s[i]);
    end
    cyc(0, 0, 1, 0);
    chk("stream_count", log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++)
      chk("stream_order", log_q[i], s[i]);

    log_q.delete();
    cyc(1, 32'hA0000AAA, 0, 0);
    chk("bp_a_acc", acc, 1);
    cyc(1, 32'hB0000BBB, 0, 0);
    chk("bp_b_acc", acc, 1);
    cyc(1, 32'hC0000CCC, 0, 0);
    chk("bp_c_wait", acc, 0);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_held", dword(), 32'hA0000AAA);
    sent = 1'b0;
    for (int k = 0; k < 5 && !sent; k++) begin
      cyc(1, 32'hC0000CCC, 1, 0);
      sent = acc;
    end
    chk("bp_c_sent", sent, 1);
    repeat (3) cyc(0, 0, 1, 0);
    chk("bp_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("bp_order0", log_q[0], 32'hA0000AAA);
      chk("bp_order1", log_q[1], 32'hB0000BBB);
      chk("bp_order2", log_q[2], 32'hC0000CCC);
    end

    log_q.delete();
    cyc(1, 32'hD0000DDD, 0, 0);
    cyc(1, 32'h50000EEE, 0, 0);
    chk("fl_skid_full", bus.in_ready, 0);
    cyc(1, 32'h60000FFF, 0, 1);
    chk("fl_out_valid", bus.out_valid, 0);
    chk("fl_in_ready", bus.in_ready, 1);
    chk("fl_fields_kept", dword(), 32'hD0000DDD);
    repeat (2) cyc(0, 0, 1, 0);
    chk("fl_nothing_out", log_q.size(), 0);

    cyc(1, 32'h70001234, 1, 0);
    cyc(1, 32'h80005678, 1, 1);
    chk("fl2_out_valid", bus.out_valid, 0);
    repeat (2) cyc(0, 0, 1, 0);
    chk("fl2_count", log_q.size(), 1);
    if (log_q.size() == 1) chk("fl2_word", log_q[0], 32'h70001234);

    log_q.delete();
    cyc(1, 32'hF0000001, 1, 0);
    chk("ill_f_valid", bus.out_valid, 1);
    chk("ill_f", illegal, 1);
    cyc(1, 32'hE0000001, 1, 0);
    chk("ill_e", illegal, 0);
    cyc(0, 0, 1, 0);
    chk("ill_xfer_count", log_q.size(), 2);
    if (log_q.size() == 2) chk("ill_f_xfer", log_q[0], 32'hF0000001);

    log_q.delete();
    cyc(1, 32'h11111111, 0, 0);
    cyc(1, 32'h22222222, 0, 0);
    bus.in_valid = 1'b0;
    #1 nreset = 1'b0;
    #1;
    chk("mrst_out_valid", bus.out_valid, 0);
    chk("mrst_in_ready", bus.in_ready, 1);
    chk("mrst_word", dword(), 0);
    @(posedge clk);
    #1 nreset = 1'b1;
    cyc(1, 32'h33333333, 1, 0);
    chk("mrst_resume", dword(), 32'h33333333);
    cyc(0, 0, 1, 0);
    chk("mrst_log", log_q.size(), 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
